// File: rtl/shift_pkg.sv
// Shared encodings for the shifter command path: FSM states, shift op codes
// and button slot indices used by the command controller.
package shift_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SLL  = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_SLA  = 3'd3;
    localparam logic [2:0] OP_SRA  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;

    localparam int BTN_STEP = 0;
    localparam int BTN_RUN  = 1;
    localparam int BTN_CLR  = 2;
    localparam int NUM_BTN  = 3;

    // Only real shifts advance the step counter; hold codes (0 and 7) pass through uncounted.
    function automatic logic op_is_counted(input logic [2:0] op);
        logic counted;
        counted = 1'b0;
        case (op)
            OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROL, OP_ROR: counted = 1'b1;
            OP_HOLD: counted = 1'b0;
            default: counted = 1'b0;
        endcase
        return counted;
    endfunction

endpackage

// File: rtl/shift_cmd_ctrl_if.sv
// Board-side bundle of the command controller: raw buttons/switches in,
// shifter command, clear pulse and status out.
interface shift_cmd_ctrl_if;

    logic       btn_step;
    logic       btn_run;
    logic       btn_clr;
    logic [2:0] sw_op;
    logic [2:0] sel;
    logic       shift_clr;
    logic       running;
    logic [7:0] step_cnt;

    modport master (
        output btn_step, btn_run, btn_clr, sw_op,
        input  sel, shift_clr, running, step_cnt
    );

    modport slave (
        input  btn_step, btn_run, btn_clr, sw_op,
        output sel, shift_clr, running, step_cnt
    );

endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debounce counter and a
// registered one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEB_COUNT = 500000,
    parameter int DEB_W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic             stable_d_reg;
    logic             press_reg;
    logic [DEB_W-1:0] cnt_reg;
    logic             sync;

    assign sync  = sync_reg[1];
    assign press = press_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg     <= '0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            press_reg    <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            sync_reg     <= {sync_reg[0], raw};
            stable_d_reg <= stable_reg;
            press_reg    <= stable_reg & ~stable_d_reg;
            // Any return to the stable level restarts the qualification window.
            if (sync == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DEB_LAST) begin
                stable_reg <= sync;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/shift_cmd_ctrl.sv
// Command stage for shifter_8bit: debounced buttons drive a manual/auto-run
// FSM that issues one-cycle shift commands and clear pulses, and counts shifts.
module shift_cmd_ctrl
    import shift_pkg::*;
#(
    parameter int DEB_COUNT = 500000,
    parameter int DEB_W     = 20,
    parameter int RUN_DIV   = 25000000,
    parameter int DIV_W     = 25
) (
    input  logic             clk,
    input  logic             reset,
    shift_cmd_ctrl_if.slave  bus
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;

    assign btn_raw[BTN_STEP] = bus.btn_step;
    assign btn_raw[BTN_RUN]  = bus.btn_run;
    assign btn_raw[BTN_CLR]  = bus.btn_clr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_deb
            btn_debounce #(
                .DEB_COUNT (DEB_COUNT),
                .DEB_W     (DEB_W)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .raw   (btn_raw[gi]),
                .press (btn_press[gi])
            );
        end
    endgenerate

    logic [2:0]       sw_meta_reg, sw_sync_reg;
    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [2:0]       sel_reg, sel_next;
    logic             clr_reg, clr_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic             issue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
            state_reg   <= ST_IDLE;
            div_reg     <= '0;
            sel_reg     <= '0;
            clr_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sw_meta_reg <= bus.sw_op;
            sw_sync_reg <= sw_meta_reg;
            state_reg   <= state_next;
            div_reg     <= div_next;
            sel_reg     <= sel_next;
            clr_reg     <= clr_next;
            cnt_reg     <= cnt_next;
        end
    end

    // Press priority clr > run > step; a run press also suppresses a coincident divider wrap.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        sel_next   = '0;
        clr_next   = 1'b0;
        cnt_next   = cnt_reg;
        issue      = 1'b0;

        if (btn_press[BTN_CLR]) begin
            clr_next   = 1'b1;
            cnt_next   = '0;
            state_next = ST_IDLE;
            div_next   = '0;
        end else if (btn_press[BTN_RUN]) begin
            state_next = (state_reg == ST_IDLE) ? ST_RUN : ST_IDLE;
            div_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    issue = btn_press[BTN_STEP];
                end
                ST_RUN: begin
                    if (div_reg == DIV_LAST) begin
                        div_next = '0;
                        issue    = 1'b1;
                    end else begin
                        div_next = div_reg + DIV_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    div_next   = '0;
                end
            endcase
        end

        if (issue) begin
            sel_next = sw_sync_reg;
            if (op_is_counted(sw_sync_reg)) begin
                cnt_next = cnt_reg + 8'd1;
            end
        end
    end

    assign bus.sel       = sel_reg;
    assign bus.shift_clr = clr_reg;
    assign bus.running   = (state_reg == ST_RUN);
    assign bus.step_cnt  = cnt_reg;

endmodule

// File: tb/tb_shift_cmd_ctrl.sv
// Bench for shift_cmd_ctrl with small debounce/divider settings; expected
// shift timing and counts come from the documented latencies and op rules.
module tb_shift_cmd_ctrl;

    localparam int DEB      = 4;
    localparam int RDIV     = 8;
    localparam int STEP_LAT = DEB + 4;   // drive after edge k -> sel in cycle after edge k+8

    typedef struct {
        int         cyc;
        logic [2:0] op;
    } sel_ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    shift_cmd_ctrl_if bus();

    shift_cmd_ctrl #(
        .DEB_COUNT (DEB),
        .DEB_W     (3),
        .RUN_DIV   (RDIV),
        .DIV_W     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int      checks = 0;
    int      errors = 0;
    int      model_cnt = 0;
    sel_ev_t sel_log[$];
    int      clr_log[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge and record any visible command pulses.
    task automatic tick();
        sel_ev_t ev;
        @(negedge clk);
        if (bus.sel !== 3'd0) begin
            ev.cyc = edge_cnt;
            ev.op  = bus.sel;
            sel_log.push_back(ev);
        end
        if (bus.shift_clr === 1'b1) clr_log.push_back(edge_cnt);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ticks_until(input int e);
        while (edge_cnt < e) tick();
    endtask

    task automatic clear_logs();
        sel_log.delete();
        clr_log.delete();
    endtask

    function automatic int model_add(input int cnt, input int op);
        return (op >= 1 && op <= 6) ? (cnt + 1) % 256 : cnt;
    endfunction

    task automatic test_reset();
        bus.btn_step = 1'b0;
        bus.btn_run  = 1'b0;
        bus.btn_clr  = 1'b0;
        bus.sw_op    = 3'd0;
        reset        = 1'b0;
        ticks(3);
        checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
        checks++; if (bus.shift_clr !== 1'b0) begin errors++; $display("FAIL reset_shift_clr: got %b want 0", bus.shift_clr); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", bus.running); end
        checks++; if (bus.step_cnt !== 8'd0) begin errors++; $display("FAIL reset_step_cnt: got %0d want 0", bus.step_cnt); end
        reset = 1'b1;
        ticks(3);
        model_cnt = 0;
    endtask

    task automatic test_step();
        int k;
        bus.sw_op = 3'd1;
        ticks(4);
        clear_logs();
        k = edge_cnt;
        bus.btn_step = 1'b1;
        ticks(10);
        bus.btn_step = 1'b0;
        ticks(10);
        model_cnt = model_add(model_cnt, 1);
        checks++; if (sel_log.size() != 1) begin errors++; $display("FAIL step_sel_count: got %0d want 1", sel_log.size()); end
        if (sel_log.size() > 0) begin
            checks++; if (sel_log[0].cyc != k + STEP_LAT) begin errors++; $display("FAIL step_latency: got edge %0d want %0d", sel_log[0].cyc - k, STEP_LAT); end
            checks++; if (sel_log[0].op !== 3'd1) begin errors++; $display("FAIL step_sel_value: got %0d want 1", sel_log[0].op); end
        end
        checks++; if (clr_log.size() != 0) begin errors++; $display("FAIL step_no_clr: got %0d pulses want 0", clr_log.size()); end
        checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL step_cnt: got %0d want %0d", bus.step_cnt, model_cnt); end
    endtask

    task automatic test_bounce();
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            bus.btn_step = 1'b1;
            ticks(2);
            bus.btn_step = 1'b0;
            ticks(2);
        end
        ticks(12);
        checks++; if (sel_log.size() != 0) begin errors++; $display("FAIL bounce_sel: got %0d pulses want 0", sel_log.size()); end
        checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL bounce_cnt: got %0d want %0d", bus.step_cnt, model_cnt); end
    endtask

    task automatic test_run();
        int k;
        bus.sw_op = 3'd5;
        ticks(4);
        clear_logs();
        k = edge_cnt;
        bus.btn_run = 1'b1;
        ticks(6);
        bus.btn_run = 1'b0;
        ticks_until(k + 7);
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL run_early: got %b want 0", bus.running); end
        ticks_until(k + 8);
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL run_enter: got %b want 1", bus.running); end
        ticks_until(k + 10);
        bus.btn_step = 1'b1;     // ignored while running
        ticks(6);
        bus.btn_step = 1'b0;
        ticks_until(k + 8 + 4 * RDIV + 2);
        checks++; if (sel_log.size() != 4) begin errors++; $display("FAIL run_shift_count: got %0d want 4", sel_log.size()); end
        for (int i = 0; i < 4 && i < sel_log.size(); i++) begin
            checks++; if (sel_log[i].cyc != k + 8 + RDIV * (i + 1)) begin errors++; $display("FAIL run_shift_time%0d: got edge %0d want %0d", i, sel_log[i].cyc - k, 8 + RDIV * (i + 1)); end
            checks++; if (sel_log[i].op !== 3'd5) begin errors++; $display("FAIL run_shift_op%0d: got %0d want 5", i, sel_log[i].op); end
        end
        for (int i = 0; i < 4; i++) model_cnt = model_add(model_cnt, 5);
        checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL run_cnt: got %0d want %0d", bus.step_cnt, model_cnt); end

        // Stop with the run press landing exactly on a divider wrap.
        clear_logs();
        ticks_until(k + 8 + 5 * RDIV);
        bus.btn_run = 1'b1;
        ticks(6);
        bus.btn_run = 1'b0;
        ticks_until(k + 8 + 5 * RDIV + 30);
        model_cnt = model_add(model_cnt, 5);
        checks++; if (sel_log.size() != 1) begin errors++; $display("FAIL stop_wrap_count: got %0d want 1", sel_log.size()); end
        if (sel_log.size() > 0) begin
            checks++; if (sel_log[0].cyc != k + 8 + 5 * RDIV) begin errors++; $display("FAIL stop_wrap_time: got edge %0d want %0d", sel_log[0].cyc - k, 8 + 5 * RDIV); end
        end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", bus.running); end
        checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL stop_cnt: got %0d want %0d", bus.step_cnt, model_cnt); end
    endtask

    task automatic test_clr_run();
        int k, kr, late;
        // Both in IDLE: clear must win, so the controller stays idle.
        clear_logs();
        k = edge_cnt;
        bus.btn_run = 1'b1;
        bus.btn_clr = 1'b1;
        ticks(6);
        bus.btn_run = 1'b0;
        bus.btn_clr = 1'b0;
        ticks_until(k + 25);
        model_cnt = 0;
        checks++; if (clr_log.size() != 1) begin errors++; $display("FAIL idle_clr_count: got %0d want 1", clr_log.size()); end
        if (clr_log.size() > 0) begin
            checks++; if (clr_log[0] != k + STEP_LAT) begin errors++; $display("FAIL idle_clr_time: got edge %0d want %0d", clr_log[0] - k, STEP_LAT); end
        end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL idle_clr_running: got %b want 0", bus.running); end
        checks++; if (sel_log.size() != 0) begin errors++; $display("FAIL idle_clr_sel: got %0d want 0", sel_log.size()); end
        checks++; if (bus.step_cnt !== 8'd0) begin errors++; $display("FAIL idle_clr_cnt: got %0d want 0", bus.step_cnt); end

        // Both in RUN.
        kr = edge_cnt;
        bus.btn_run = 1'b1;
        ticks(6);
        bus.btn_run = 1'b0;
        ticks_until(kr + 20);
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL rerun_running: got %b want 1", bus.running); end
        clear_logs();
        k = edge_cnt;
        bus.btn_run = 1'b1;
        bus.btn_clr = 1'b1;
        ticks(6);
        bus.btn_run = 1'b0;
        bus.btn_clr = 1'b0;
        ticks_until(k + 40);
        model_cnt = 0;
        late = 0;
        foreach (sel_log[i]) if (sel_log[i].cyc >= k + STEP_LAT) late++;
        checks++; if (clr_log.size() != 1) begin errors++; $display("FAIL run_clr_count: got %0d want 1", clr_log.size()); end
        if (clr_log.size() > 0) begin
            checks++; if (clr_log[0] != k + STEP_LAT) begin errors++; $display("FAIL run_clr_time: got edge %0d want %0d", clr_log[0] - k, STEP_LAT); end
        end
        checks++; if (late != 0) begin errors++; $display("FAIL run_clr_sel: got %0d pulses at/after clear want 0", late); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL run_clr_running: got %b want 0", bus.running); end
        checks++; if (bus.step_cnt !== 8'd0) begin errors++; $display("FAIL run_clr_cnt: got %0d want 0", bus.step_cnt); end
    endtask

    task automatic test_hold_ops();
        int k;
        logic [2:0] ops [2];
        ops[0] = 3'd0;
        ops[1] = 3'd7;
        for (int i = 0; i < 2; i++) begin
            bus.sw_op = ops[i];
            ticks(4);
            clear_logs();
            k = edge_cnt;
            bus.btn_step = 1'b1;
            ticks(6);
            bus.btn_step = 1'b0;
            ticks_until(k + 16);
            checks++; if (sel_log.size() != (ops[i] != 3'd0 ? 1 : 0)) begin errors++; $display("FAIL hold_sel_count op%0d: got %0d", ops[i], sel_log.size()); end
            if (sel_log.size() > 0) begin
                checks++; if (sel_log[0].op !== ops[i] || sel_log[0].cyc != k + STEP_LAT) begin errors++; $display("FAIL hold_sel op%0d: got %0d at edge %0d want at %0d", ops[i], sel_log[0].op, sel_log[0].cyc - k, STEP_LAT); end
            end
            checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL hold_cnt op%0d: got %0d want %0d", ops[i], bus.step_cnt, model_cnt); end
        end
    endtask

    // Random ops with random short glitches on any button; runs until the count sits at 255.
    task automatic test_random_ops();
        int k, op, hold, gl;
        logic [2:0] mask;
        for (int it = 0; it < 1500 && model_cnt != 255; it++) begin
            op = int'($urandom_range(0, 7));
            bus.sw_op = 3'(op);
            if ($urandom_range(0, 2) == 0) begin
                mask = 3'($urandom_range(1, 7));
                gl   = int'($urandom_range(1, DEB - 1));
                bus.btn_step = mask[0];
                bus.btn_run  = mask[1];
                bus.btn_clr  = mask[2];
                ticks(gl);
                bus.btn_step = 1'b0;
                bus.btn_run  = 1'b0;
                bus.btn_clr  = 1'b0;
                ticks(2);
            end
            ticks(3);
            clear_logs();
            k    = edge_cnt;
            hold = int'($urandom_range(DEB, DEB + 3));
            bus.btn_step = 1'b1;
            ticks(hold);
            bus.btn_step = 1'b0;
            ticks_until(k + hold + 9);
            model_cnt = model_add(model_cnt, op);
            checks++; if (sel_log.size() != (op != 0 ? 1 : 0) || clr_log.size() != 0) begin errors++; $display("FAIL rand_events it%0d op%0d: got %0d sel %0d clr", it, op, sel_log.size(), clr_log.size()); end
            if (sel_log.size() > 0) begin
                checks++; if (sel_log[0].op !== 3'(op) || sel_log[0].cyc != k + STEP_LAT) begin errors++; $display("FAIL rand_sel it%0d: got %0d at edge %0d want %0d at %0d", it, sel_log[0].op, sel_log[0].cyc - k, op, STEP_LAT); end
            end
            checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL rand_cnt it%0d: got %0d want %0d", it, bus.step_cnt, model_cnt); end
        end
    endtask

    task automatic test_wrap();
        int k;
        checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL wrap_pre_cnt: got %0d want %0d", bus.step_cnt, model_cnt); end
        bus.sw_op = 3'd2;
        ticks(4);
        clear_logs();
        k = edge_cnt;
        bus.btn_step = 1'b1;
        ticks(6);
        bus.btn_step = 1'b0;
        ticks_until(k + 16);
        model_cnt = model_add(model_cnt, 2);
        checks++; if (sel_log.size() != 1) begin errors++; $display("FAIL wrap_sel_count: got %0d want 1", sel_log.size()); end
        checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL wrap_cnt: got %0d want %0d", bus.step_cnt, model_cnt); end
    endtask

    task automatic test_reset_in_run();
        int k;
        bit found;
        bus.sw_op = 3'd3;
        ticks(4);
        bus.btn_run = 1'b1;
        ticks(6);
        bus.btn_run = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.sel !== 3'd0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_run_no_shift: got none want a sel pulse within 40 cycles"); end
        reset = 1'b0;
        #1;
        model_cnt = 0;
        checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL rst_run_sel: got %0d want 0", bus.sel); end
        checks++; if (bus.shift_clr !== 1'b0) begin errors++; $display("FAIL rst_run_clr: got %b want 0", bus.shift_clr); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rst_run_running: got %b want 0", bus.running); end
        checks++; if (bus.step_cnt !== 8'd0) begin errors++; $display("FAIL rst_run_cnt: got %0d want 0", bus.step_cnt); end
        ticks(3);
        reset = 1'b1;
        clear_logs();
        ticks(30);
        checks++; if (sel_log.size() != 0 || clr_log.size() != 0) begin errors++; $display("FAIL post_rst_quiet: got %0d sel %0d clr want 0 0", sel_log.size(), clr_log.size()); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL post_rst_running: got %b want 0", bus.running); end
        clear_logs();
        k = edge_cnt;
        bus.btn_step = 1'b1;
        ticks(6);
        bus.btn_step = 1'b0;
        ticks_until(k + 16);
        model_cnt = model_add(model_cnt, 3);
        checks++; if (sel_log.size() != 1) begin errors++; $display("FAIL post_rst_step: got %0d pulses want 1", sel_log.size()); end
        checks++; if (bus.step_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL post_rst_cnt: got %0d want %0d", bus.step_cnt, model_cnt); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_run();
        test_clr_run();
        test_hold_ops();
        test_random_ops();
        test_wrap();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
